tdc_measure_ctrl: RTL
=====================

TDC_MEASURE_CTRL -- requirements
Module: tdc_measure_ctrl

Interface
REQ-001 SHALL have parameter N_TAPS, default 32: number of delay-line taps in the thermometer snapshot.
REQ-002 SHALL have parameter COARSE_W, default 8: coarse cycle-counter width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: result FIFO entries (power of two, >=2).
REQ-004 SHALL derive FINE_W = clog2(N_TAPS+1) and RES_W = 1+COARSE_W+FINE_W.
REQ-005 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port start  input  1  one-cycle pulse (already synchronised) that begins a measurement.
REQ-008 SHALL have port stop  input  1  one-cycle pulse; taps is valid in the same cycle.
REQ-009 SHALL have port taps  input  N_TAPS  thermometer snapshot from the external delay line.
REQ-010 SHALL have port rd_ready  input  1  consumer accepts rd_data.
REQ-011 SHALL have port clr  input  1  clears the overflow flag.
REQ-012 SHALL have port rd_valid  output  1  FIFO non-empty.
REQ-013 SHALL have port rd_data  output  RES_W  {timeout, coarse, fine} at FIFO head.
REQ-014 SHALL have port busy  output  1  high in MEASURE and DONE.
REQ-015 SHALL have port overflow  output  1  sticky: a result was dropped.
REQ-016 SHALL have port level  output  clog2(FIFO_DEPTH+1)  FIFO occupancy.

Function
REQ-017 SHALL implement FSM IDLE, MEASURE, DONE.
REQ-018 SHALL, on IDLE with start sampled, clear the coarse counter to 0 and enter MEASURE.
REQ-019 SHALL increment the coarse counter on every MEASURE edge without stop.
REQ-020 SHALL, on MEASURE with stop sampled, capture coarse = counter value before increment, fine = popcount(taps), timeout=0, then enter DONE.
REQ-021 SHALL, with no stop when the counter equals 2^COARSE_W-1, capture {1, all-ones, 0} and enter DONE.
REQ-022 SHALL, in DONE, write the captured result to the FIFO and return to IDLE; rd_valid rises the cycle after the DONE edge (2 edges after stop).
REQ-023 SHALL use popcount, not leading-one position, for fine so single-tap bubbles are tolerated.
REQ-024 SHALL ignore stop in IDLE/DONE and start in MEASURE/DONE; start and stop together in IDLE -> start taken, stop ignored.
REQ-025 SHALL pop the FIFO head on edges where rd_valid and rd_ready are both high; rd_data is the head, unregistered from storage.
REQ-026 SHALL, on write while full without a same-cycle pop, drop the result and set overflow; full with same-cycle pop accepts the write.
REQ-027 SHALL clear overflow on clr; clr and a drop together leave overflow set.
REQ-028 SHALL wrap read/write pointers modulo FIFO_DEPTH.

Reset
REQ-029 SHALL, on rst_n low, force IDLE, counter 0, FIFO empty, rd_valid 0, busy 0, overflow 0, level 0, rd_data 0, at any point including mid-MEASURE.

Structure
REQ-030 SHALL place the FSM state enum, result field layout and a width-helper function in shared package tdc_pkg.
REQ-031 SHALL implement the FIFO as sub-module tdc_result_fifo (parametrised WIDTH, DEPTH).

Verification (N_TAPS=32, COARSE_W=8, FIFO_DEPTH=4)
REQ-032 SHALL cover: start, stop 5 edges later, taps=0x000000FF -> rd_data={0,8'd5,6'd8}, rd_valid 2 edges after stop.
REQ-033 SHALL cover: bubbled taps=0x00000F7F -> fine=11.
REQ-034 SHALL cover: start, no stop -> after 256 MEASURE edges rd_data={1,8'hFF,6'd0}, busy low.
REQ-035 SHALL cover: 5 measurements, rd_ready=0 -> level=4, overflow=1, first 4 results intact in order; clr -> overflow=0.
REQ-036 SHALL cover: rst_n low mid-MEASURE -> busy=0, rd_valid=0, level=0; next start/stop measures normally.
REQ-037 SHALL cover: start+stop same cycle in IDLE, and start pulse during MEASURE -> single measurement, coarse counted from first start.

Source files
------------

// File: rtl/tdc_pkg.sv
// Shared definitions for the TDC measurement controller: FSM states,
// result field layout and width helpers.
package tdc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  // Result word, MSB first: {timeout, coarse[COARSE_W-1:0], fine[FINE_W-1:0]}
  localparam int unsigned TIMEOUT_W = 1;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    if (value > 1) begin
      for (int unsigned v = value - 1; v > 0; v = v >> 1) r++;
    end
    return r;
  endfunction

  // Fine field must hold popcounts 0..n_taps inclusive.
  function automatic int unsigned calc_fine_w(input int unsigned n_taps);
    return clog2(n_taps + 1);
  endfunction

  function automatic int unsigned calc_res_w(input int unsigned coarse_w,
                                             input int unsigned n_taps);
    return TIMEOUT_W + coarse_w + calc_fine_w(n_taps);
  endfunction

endpackage

// File: rtl/tdc_result_fifo.sv
// Result FIFO: registered occupancy/valid, head presented straight from storage,
// writes into a full FIFO are accepted only when a pop happens on the same edge.
module tdc_result_fifo
  import tdc_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = clog2(DEPTH),
  localparam int unsigned CNT_W = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_ready,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0] level,
  output logic             drop_c
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full_c;
  logic             pop_c;
  logic             push_c;
  logic [CNT_W-1:0] level_nxt_c;

  assign full_c  = (level == CNT_W'(DEPTH));
  assign pop_c   = rd_valid && rd_ready;
  assign push_c  = wr_en && (!full_c || pop_c);
  assign drop_c  = wr_en && full_c && !pop_c;
  assign rd_data = mem[rd_ptr];

  always_comb begin
    level_nxt_c = level;
    if (push_c && !pop_c) begin
      level_nxt_c = level + CNT_W'(1);
    end else if (pop_c && !push_c) begin
      level_nxt_c = level - CNT_W'(1);
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (push_c) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      level    <= level_nxt_c;
      rd_valid <= (level_nxt_c != '0);
    end
  end

endmodule

// File: rtl/tdc_measure_ctrl.sv
// TDC measurement controller: coarse cycle count between start and stop,
// fine value from the popcount of the delay-line snapshot, results queued in a FIFO.
module tdc_measure_ctrl
  import tdc_pkg::*;
#(
  parameter int unsigned N_TAPS     = 32,
  parameter int unsigned COARSE_W   = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned FINE_W  = calc_fine_w(N_TAPS),
  localparam int unsigned RES_W   = calc_res_w(COARSE_W, N_TAPS),
  localparam int unsigned LEVEL_W = clog2(FIFO_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [N_TAPS-1:0]  taps,
  input  logic               rd_ready,
  input  logic               clr,
  output logic               rd_valid,
  output logic [RES_W-1:0]   rd_data,
  output logic               busy,
  output logic               overflow,
  output logic [LEVEL_W-1:0] level
);

  localparam logic [COARSE_W-1:0] CNT_MAX = '1;

  state_t              state;
  logic [COARSE_W-1:0] coarse_cnt;
  logic [RES_W-1:0]    result;
  logic [FINE_W-1:0]   fine_c;
  logic                wr_en_c;
  logic                drop_c;

  // Popcount rather than leading-one so a single bubble costs at most one LSB.
  always_comb begin
    fine_c = '0;
    for (int unsigned i = 0; i < N_TAPS; i++) begin
      fine_c = fine_c + FINE_W'(taps[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      coarse_cnt <= '0;
      result     <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            coarse_cnt <= '0;
            busy       <= 1'b1;
            state      <= ST_MEASURE;
          end
        end
        ST_MEASURE: begin
          if (stop) begin
            result <= {1'b0, coarse_cnt, fine_c};
            state  <= ST_DONE;
          end else if (coarse_cnt == CNT_MAX) begin
            result <= {1'b1, CNT_MAX, FINE_W'(0)};
            state  <= ST_DONE;
          end else begin
            coarse_cnt <= coarse_cnt + COARSE_W'(1);
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign wr_en_c = (state == ST_DONE);

  // A drop on the same edge as clr wins so no lost result goes unreported.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (drop_c) begin
      overflow <= 1'b1;
    end else if (clr) begin
      overflow <= 1'b0;
    end
  end

  tdc_result_fifo #(
    .WIDTH (RES_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en_c),
    .wr_data  (result),
    .rd_ready (rd_ready),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .level    (level),
    .drop_c   (drop_c)
  );

endmodule
